wgt_loader: RTL and testbench

//  Write side of the PE weight path. Accepts a byte stream of kernels (bias, then rows).

---
 rtl/pe_cfg_pkg.sv | 46 ++++
 rtl/wgt_loader_if.sv | 45 ++++
 rtl/wgt_row_packer.sv | 41 ++++
 rtl/wgt_loader.sv | 151 +++++++++++++++
 tb/tb_wgt_loader.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared PE weight-path configuration: mode encodings, FSM state codes and
// per-mode kernel geometry lookups used by the weight loader.
package pe_cfg_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROW_NUM    = 6;

    typedef enum logic [1:0] {
        MODE_2X3X3 = 2'b00,
        MODE_4X4   = 2'b01,
        MODE_5X5   = 2'b10,
        MODE_6X6   = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_ROW   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Rows per kernel: mode 00 carries two 3x3 kernels side by side in 3 rows.
    function automatic logic [2:0] kernel_rows_of(input mode_t m);
        case (m)
            MODE_2X3X3: kernel_rows_of = 3'd3;
            MODE_4X4:   kernel_rows_of = 3'd4;
            MODE_5X5:   kernel_rows_of = 3'd5;
            default:    kernel_rows_of = 3'd6;
        endcase
    endfunction

    function automatic logic [2:0] row_bytes_of(input mode_t m);
        case (m)
            MODE_2X3X3: row_bytes_of = 3'd6;
            MODE_4X4:   row_bytes_of = 3'd4;
            MODE_5X5:   row_bytes_of = 3'd5;
            default:    row_bytes_of = 3'd6;
        endcase
    endfunction

    function automatic logic [2:0] bias_bytes_of(input mode_t m);
        bias_bytes_of = (m == MODE_2X3X3) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/wgt_loader_if.sv
// Command, byte-stream and wmem write bus of the weight loader.
// o_checksum only exists when WGT_LOADER_CHECKSUM_EN is defined.
interface wgt_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 6,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
);
    logic                           i_start;
    logic [1:0]                     i_mode;
    logic [ADDR_WIDTH-1:0]          i_base_addr;
    logic [CNT_WIDTH-1:0]           i_kernel_num;
    logic                           i_wgt_valid;
    logic [DATA_WIDTH-1:0]          i_wgt_data;
    logic                           o_wgt_ready;
    logic [ROW_NUM-1:0]             o_wr_en;
    logic [ADDR_WIDTH-1:0]          o_wr_addr;
    logic [DATA_WIDTH*ROW_NUM-1:0]  o_wr_data;
    logic                           o_bias_wr_en;
    logic [2*OUT_WIDTH-1:0]         o_bias_data;
    logic                           o_busy;
    logic                           o_done;
`ifdef WGT_LOADER_CHECKSUM_EN
    logic [15:0]                    o_checksum;
`endif

    modport master (
        output i_start, i_mode, i_base_addr, i_kernel_num, i_wgt_valid, i_wgt_data,
        input  o_wgt_ready, o_wr_en, o_wr_addr, o_wr_data, o_bias_wr_en, o_bias_data,
        input  o_busy, o_done
`ifdef WGT_LOADER_CHECKSUM_EN
        , input o_checksum
`endif
    );

    modport slave (
        input  i_start, i_mode, i_base_addr, i_kernel_num, i_wgt_valid, i_wgt_data,
        output o_wgt_ready, o_wr_en, o_wr_addr, o_wr_data, o_bias_wr_en, o_bias_data,
        output o_busy, o_done
`ifdef WGT_LOADER_CHECKSUM_EN
        , output o_checksum
`endif
    );
endinterface

// File: rtl/wgt_row_packer.sv
// Assembles stream bytes into one packed kernel row, byte j in lane j.
// row_word already includes the byte on the input so the caller can write it on the last byte.
module wgt_row_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          byte_fire,
    input  logic [DATA_WIDTH-1:0]         byte_data,
    input  logic [2:0]                    row_bytes,
    output logic [DATA_WIDTH*ROW_NUM-1:0] row_word,
    output logic                          last_byte
);
    logic [2:0]                    lane;
    logic [DATA_WIDTH*ROW_NUM-1:0] asm_q;

    always_comb begin
        row_word = asm_q;
        row_word[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = byte_data;
    end

    assign last_byte = (lane == row_bytes - 3'd1);

    // Clearing at each row end keeps the unused upper lanes zero for short rows.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane  <= '0;
            asm_q <= '0;
        end else if (byte_fire) begin
            if (last_byte) begin
                lane  <= '0;
                asm_q <= '0;
            end else begin
                lane  <= lane + 3'd1;
                asm_q <= row_word;
            end
        end
    end
endmodule

// File: rtl/wgt_loader.sv
// PE weight loader: packs a bias+rows byte stream into wmem row-bank and bias writes.
// Optional WGT_LOADER_CHECKSUM_EN adds a 16-bit byte checksum output.
module wgt_loader
    import pe_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROW_NUM    = DEF_ROW_NUM,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_rst,
    wgt_loader_if.slave  bus
);
    localparam int ROW_DATA_WIDTH = DATA_WIDTH * ROW_NUM;

    state_t                    state;
    mode_t                     mode_q;
    logic [ADDR_WIDTH-1:0]     addr_cur;
    logic [CNT_WIDTH-1:0]      kern_left;
    logic [1:0]                bias_cnt;
    logic [2:0]                row_idx;
    logic [2*OUT_WIDTH-1:0]    bias_q;
    logic [2*OUT_WIDTH-1:0]    bias_next;

    logic [ROW_NUM-1:0]        wr_en_q;
    logic [ADDR_WIDTH-1:0]     wr_addr_q;
    logic [ROW_DATA_WIDTH-1:0] wr_data_q;
    logic                      bias_wr_en_q;
    logic [2*OUT_WIDTH-1:0]    bias_data_q;

    logic                      ready;
    logic                      fire;
    logic                      cmd_accept;
    logic                      row_last;
    logic [ROW_DATA_WIDTH-1:0] row_word;

    assign ready      = (state == ST_BIAS) || (state == ST_ROW);
    assign fire       = bus.i_wgt_valid && ready;
    assign cmd_accept = (state == ST_IDLE) && bus.i_start;

    always_comb begin
        bias_next = bias_q;
        bias_next[int'(bias_cnt)*DATA_WIDTH +: DATA_WIDTH] = bus.i_wgt_data;
    end

    wgt_row_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_NUM    (ROW_NUM)
    ) u_packer (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (cmd_accept),
        .byte_fire (fire && (state == ST_ROW)),
        .byte_data (bus.i_wgt_data),
        .row_bytes (row_bytes_of(mode_q)),
        .row_word  (row_word),
        .last_byte (row_last)
    );

    // An empty command still passes through FLUSH so o_done lands two cycles after the strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_2X3X3;
            addr_cur     <= '0;
            kern_left    <= '0;
            bias_cnt     <= '0;
            row_idx      <= '0;
            bias_q       <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            bias_wr_en_q <= 1'b0;
            bias_data_q  <= '0;
        end else begin
            wr_en_q      <= '0;
            bias_wr_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        mode_q    <= mode_t'(bus.i_mode);
                        addr_cur  <= bus.i_base_addr;
                        kern_left <= bus.i_kernel_num;
                        bias_cnt  <= '0;
                        row_idx   <= '0;
                        bias_q    <= '0;
                        state     <= (bus.i_kernel_num == '0) ? ST_FLUSH : ST_BIAS;
                    end
                end
                ST_BIAS: begin
                    if (fire) begin
                        if ({1'b0, bias_cnt} == bias_bytes_of(mode_q) - 3'd1) begin
                            bias_cnt     <= '0;
                            bias_q       <= '0;
                            bias_data_q  <= bias_next;
                            bias_wr_en_q <= 1'b1;
                            wr_addr_q    <= addr_cur;
                            state        <= ST_ROW;
                        end else begin
                            bias_cnt <= bias_cnt + 2'd1;
                            bias_q   <= bias_next;
                        end
                    end
                end
                ST_ROW: begin
                    if (fire && row_last) begin
                        wr_en_q   <= ROW_NUM'(1) << row_idx;
                        wr_data_q <= row_word;
                        wr_addr_q <= addr_cur;
                        if (row_idx == kernel_rows_of(mode_q) - 3'd1) begin
                            row_idx   <= '0;
                            addr_cur  <= addr_cur + ADDR_WIDTH'(1);
                            kern_left <= kern_left - CNT_WIDTH'(1);
                            state     <= (kern_left == CNT_WIDTH'(1)) ? ST_FLUSH : ST_BIAS;
                        end else begin
                            row_idx <= row_idx + 3'd1;
                        end
                    end
                end
                ST_FLUSH: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef WGT_LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || cmd_accept) begin
            csum_q <= '0;
        end else if (fire) begin
            csum_q <= csum_q + 16'(bus.i_wgt_data);
        end
    end

    assign bus.o_checksum = csum_q;
`endif

    assign bus.o_wgt_ready  = ready;
    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_wr_addr    = wr_addr_q;
    assign bus.o_wr_data    = wr_data_q;
    assign bus.o_bias_wr_en = bias_wr_en_q;
    assign bus.o_bias_data  = bias_data_q;
    assign bus.o_busy       = (state == ST_BIAS) || (state == ST_ROW) || (state == ST_FLUSH);
    assign bus.o_done       = (state == ST_DONE);
endmodule

// File: tb/tb_wgt_loader.sv
// Directed bench for wgt_loader: logs every write/bias/done pulse and checks them
// against hand-computed values and a small stream-geometry model.
module tb_wgt_loader;
    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    wgt_loader_if bus ();

    wgt_loader dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [5:0]  en;
        logic [7:0]  addr;
        logic [47:0] data;
    } wr_rec_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } bias_rec_t;

    wr_rec_t    wr_q[$];
    wr_rec_t    exp_wr_q[$];
    bias_rec_t  bias_q[$];
    bias_rec_t  exp_bias_q[$];
    int         done_q[$];
    int         hs_q[$];
    logic [7:0] stim_q[$];

    int cyc = 0;
    int error_count = 0;
    int check_count = 0;
    int start_cyc;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; cyc here is the index of the cycle being observed.
    always @(negedge i_clk) begin
        if (bus.o_wr_en != 6'd0)
            wr_q.push_back('{cyc, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data});
        if (bus.o_bias_wr_en)
            bias_q.push_back('{cyc, bus.o_wr_addr, bus.o_bias_data});
        if (bus.o_done)
            done_q.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        bias_q.delete();
        done_q.delete();
        hs_q.delete();
    endtask

    function automatic int rows_of(input logic [1:0] m);
        return (m == 2'b00) ? 3 : (m == 2'b01) ? 4 : (m == 2'b10) ? 5 : 6;
    endfunction

    function automatic int bytes_of(input logic [1:0] m);
        return (m == 2'b00) ? 6 : (m == 2'b01) ? 4 : (m == 2'b10) ? 5 : 6;
    endfunction

    // Reference layout of a command: per kernel NB bias bytes then K rows of B bytes.
    task automatic build_expected(input logic [1:0] m, input logic [7:0] base, input int kn);
        int idx = 0;
        logic [7:0] addr = base;
        exp_wr_q.delete();
        exp_bias_q.delete();
        for (int k = 0; k < kn; k++) begin
            logic [31:0] b = '0;
            for (int j = 0; j < ((m == 2'b00) ? 4 : 2); j++) begin
                b[8*j +: 8] = stim_q[idx];
                idx++;
            end
            exp_bias_q.push_back('{0, addr, b});
            for (int r = 0; r < rows_of(m); r++) begin
                logic [47:0] d = '0;
                for (int j = 0; j < bytes_of(m); j++) begin
                    d[8*j +: 8] = stim_q[idx];
                    idx++;
                end
                exp_wr_q.push_back('{0, 6'(1 << r), addr, d});
            end
            addr = addr + 8'd1;
        end
    endtask

    task automatic start_cmd(input logic [1:0] m, input logic [7:0] base, input logic [7:0] kn);
        bus.i_start      = 1'b1;
        bus.i_mode       = m;
        bus.i_base_addr  = base;
        bus.i_kernel_num = kn;
        start_cyc        = cyc;
        @(negedge i_clk);
        bus.i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int budget = 0;
        for (int g = 0; g < gap; g++) begin
            bus.i_wgt_valid = 1'b0;
            @(negedge i_clk);
        end
        bus.i_wgt_valid = 1'b1;
        bus.i_wgt_data  = b;
        if (poke) begin
            bus.i_start      = 1'($urandom_range(0, 1));
            bus.i_mode       = 2'($urandom_range(0, 3));
            bus.i_base_addr  = 8'($urandom_range(0, 255));
            bus.i_kernel_num = 8'($urandom_range(0, 255));
        end
        while (!bus.o_wgt_ready && budget < 50) begin
            @(negedge i_clk);
            budget++;
        end
        if (!bus.o_wgt_ready)
            checkOutput("ready_wait", 64'(bus.o_wgt_ready), 64'd1);
        hs_q.push_back(cyc);
        @(negedge i_clk);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] base, input logic [7:0] kn,
                                 input int max_gap, input bit poke);
        int n = 0;
        start_cmd(m, base, kn);
        foreach (stim_q[i])
            send_byte(stim_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, poke);
        bus.i_wgt_valid = 1'b0;
        bus.i_start     = 1'b0;
        while (done_q.size() == 0 && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        repeat (3) @(negedge i_clk);
    endtask

    task automatic compare_logs(input string tag);
        checkOutput({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_wr_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++) begin
            checkOutput($sformatf("%s_wr%0d_en", tag, i), 64'(wr_q[i].en), 64'(exp_wr_q[i].en));
            checkOutput($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_q[i].addr), 64'(exp_wr_q[i].addr));
            checkOutput($sformatf("%s_wr%0d_data", tag, i), 64'(wr_q[i].data), 64'(exp_wr_q[i].data));
        end
        checkOutput({tag, "_bias_count"}, 64'(bias_q.size()), 64'(exp_bias_q.size()));
        for (int i = 0; i < bias_q.size() && i < exp_bias_q.size(); i++) begin
            checkOutput($sformatf("%s_bias%0d_data", tag, i), 64'(bias_q[i].data), 64'(exp_bias_q[i].data));
            checkOutput($sformatf("%s_bias%0d_addr", tag, i), 64'(bias_q[i].addr), 64'(exp_bias_q[i].addr));
        end
        checkOutput({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
    endtask

    initial begin
        logic [5:0]  en_or;
        logic [15:0] hi_or;
        i_rst            = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_mode       = 2'b00;
        bus.i_base_addr  = 8'd0;
        bus.i_kernel_num = 8'd0;
        bus.i_wgt_valid  = 1'b0;
        bus.i_wgt_data   = 8'd0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        $display("[TB] reset state");
        checkOutput("rst_wr_en", 64'(bus.o_wr_en), 64'd0);
        checkOutput("rst_wr_addr", 64'(bus.o_wr_addr), 64'd0);
        checkOutput("rst_wr_data", 64'(bus.o_wr_data), 64'd0);
        checkOutput("rst_bias_wr_en", 64'(bus.o_bias_wr_en), 64'd0);
        checkOutput("rst_bias_data", 64'(bus.o_bias_data), 64'd0);
        checkOutput("rst_ready", 64'(bus.o_wgt_ready), 64'd0);
        checkOutput("rst_busy", 64'(bus.o_busy), 64'd0);
        checkOutput("rst_done", 64'(bus.o_done), 64'd0);

        $display("[TB] test 1: 6x6, base 5, one kernel");
        clear_logs();
        stim_q = '{8'h34, 8'h12};
        for (int i = 1; i <= 36; i++) stim_q.push_back(8'(i));
        build_expected(2'b11, 8'd5, 1);
        applyStimulus(2'b11, 8'd5, 8'd1, 0, 1'b0);
        compare_logs("t1");
        if (bias_q.size() == 1) begin
            checkOutput("t1_bias_val", 64'(bias_q[0].data), 64'h1234);
            checkOutput("t1_bias_addr", 64'(bias_q[0].addr), 64'd5);
            checkOutput("t1_bias_lat", 64'(bias_q[0].cyc), 64'(hs_q[1] + 1));
        end
        if (wr_q.size() == 6) begin
            checkOutput("t1_row0_en", 64'(wr_q[0].en), 64'h01);
            checkOutput("t1_row0_data", 64'(wr_q[0].data), 64'h060504030201);
            checkOutput("t1_row0_lat", 64'(wr_q[0].cyc), 64'(hs_q[7] + 1));
            checkOutput("t1_row5_en", 64'(wr_q[5].en), 64'h20);
            checkOutput("t1_row5_data", 64'(wr_q[5].data), 64'h24232221201F);
        end
        if (done_q.size() == 1)
            checkOutput("t1_done_lat", 64'(done_q[0]), 64'(hs_q[37] + 2));
`ifdef WGT_LOADER_CHECKSUM_EN
        checkOutput("t1_checksum", 64'(bus.o_checksum), 64'h02E0);
`endif

        $display("[TB] test 2: 4x4, base 0, two kernels, full rate");
        clear_logs();
        stim_q.delete();
        for (int k = 0; k < 2; k++) begin
            stim_q.push_back(8'(8'hA0 + k));
            stim_q.push_back(8'h0A);
            for (int i = 0; i < 16; i++) stim_q.push_back(8'(k * 64 + 16 + i));
        end
        build_expected(2'b01, 8'd0, 2);
        applyStimulus(2'b01, 8'd0, 8'd2, 0, 1'b0);
        compare_logs("t2");
        en_or = '0;
        hi_or = '0;
        foreach (wr_q[i]) begin
            en_or |= wr_q[i].en;
            hi_or |= wr_q[i].data[47:32];
        end
        checkOutput("t2_en_upper", 64'(en_or & 6'h30), 64'd0);
        checkOutput("t2_data_upper", 64'(hi_or), 64'd0);
        if (wr_q.size() == 8) begin
            checkOutput("t2_addr_first", 64'(wr_q[0].addr), 64'd0);
            checkOutput("t2_addr_last", 64'(wr_q[7].addr), 64'd1);
        end
        checkOutput("t2_no_bubble", 64'(hs_q[35] - hs_q[0]), 64'd35);

        $display("[TB] test 3: 2x3x3 pair packing");
        clear_logs();
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int r = 0; r < 3; r++) begin
            stim_q.push_back(8'hA1); stim_q.push_back(8'hA2); stim_q.push_back(8'hA3);
            stim_q.push_back(8'hB1); stim_q.push_back(8'hB2); stim_q.push_back(8'hB3);
        end
        build_expected(2'b00, 8'h40, 1);
        applyStimulus(2'b00, 8'h40, 8'd1, 0, 1'b0);
        compare_logs("t3");
        if (bias_q.size() == 1)
            checkOutput("t3_bias_val", 64'(bias_q[0].data), 64'h44332211);
        checkOutput("t3_row_writes", 64'(wr_q.size()), 64'd3);
        foreach (wr_q[i])
            checkOutput($sformatf("t3_row%0d_val", i), 64'(wr_q[i].data), 64'hB3B2B1A3A2A1);

        $display("[TB] test 4: 5x5 with valid gaps and start pokes while busy");
        clear_logs();
        stim_q.delete();
        for (int i = 0; i < 54; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        build_expected(2'b10, 8'h20, 2);
        applyStimulus(2'b10, 8'h20, 8'd2, 3, 1'b1);
        bus.i_mode       = 2'b00;
        bus.i_base_addr  = 8'd0;
        bus.i_kernel_num = 8'd0;
        repeat (10) @(negedge i_clk);
        compare_logs("t4");
        checkOutput("t4_idle_busy", 64'(bus.o_busy), 64'd0);

        $display("[TB] test 5: reset inside row 2");
        clear_logs();
        start_cmd(2'b11, 8'd0, 8'd1);
        for (int i = 0; i < 17; i++) send_byte(8'(i + 1), 0, 1'b0);
        i_rst           = 1'b1;
        bus.i_wgt_valid = 1'b1;
        bus.i_wgt_data  = 8'h99;
        @(negedge i_clk);
        i_rst           = 1'b0;
        bus.i_wgt_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        checkOutput("t5_wr_count", 64'(wr_q.size()), 64'd2);
        checkOutput("t5_bias_count", 64'(bias_q.size()), 64'd1);
        checkOutput("t5_no_done", 64'(done_q.size()), 64'd0);
        checkOutput("t5_busy", 64'(bus.o_busy), 64'd0);
        checkOutput("t5_ready", 64'(bus.o_wgt_ready), 64'd0);
        clear_logs();
        stim_q.delete();
        for (int i = 0; i < 18; i++) stim_q.push_back(8'(8'hC0 + i));
        build_expected(2'b01, 8'd3, 1);
        applyStimulus(2'b01, 8'd3, 8'd1, 0, 1'b0);
        compare_logs("t5_fresh");

        $display("[TB] test 6: address wrap and empty command");
        clear_logs();
        stim_q.delete();
        for (int i = 0; i < 36; i++) stim_q.push_back(8'(i * 7 + 3));
        build_expected(2'b01, 8'hFF, 2);
        applyStimulus(2'b01, 8'hFF, 8'd2, 0, 1'b0);
        compare_logs("t6");
        if (wr_q.size() == 8) begin
            checkOutput("t6_addr_first", 64'(wr_q[0].addr), 64'hFF);
            checkOutput("t6_addr_wrap", 64'(wr_q[7].addr), 64'h00);
        end
        clear_logs();
        stim_q.delete();
        applyStimulus(2'b01, 8'h10, 8'd0, 0, 1'b0);
        checkOutput("t6_empty_done_count", 64'(done_q.size()), 64'd1);
        if (done_q.size() == 1)
            checkOutput("t6_empty_done_lat", 64'(done_q[0]), 64'(start_cyc + 2));
        checkOutput("t6_empty_writes", 64'(wr_q.size()), 64'd0);
        checkOutput("t6_empty_bias", 64'(bias_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end
endmodule
